serial_subtractor_dataflow: RTL
===============================

// Module: serial_subtractor_dataflow
// PURPOSE
//   Multi-cycle digit-serial subtractor: diff = a - b - bin, processed DIGIT bits per clock, LSB digit first.
//   Internal borrow chain is the subtraction counterpart of the team's ripple/look-ahead carry adders.
//   Sits behind a valid/ready input channel and a valid/ready result channel, so datapath arithmetic can stall.
//   Also reports borrow-out, zero and signed-overflow flags.
// PARAMETERS
//   WIDTH  16  operand/result width in bits; must be a multiple of DIGIT
//   DIGIT  4   bits subtracted per RUN cycle; N = WIDTH/DIGIT RUN cycles per operation (DIGIT=WIDTH gives N=1)
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operand bundle valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   a          in   WIDTH  minuend
//   b          in   WIDTH  subtrahend
//   bin        in   1      borrow-in
//   out_valid  out  1      result bundle valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   diff       out  WIDTH  a - b - bin, modulo 2^WIDTH
//   bout       out  1      borrow-out: 1 when unsigned a < b + bin
//   zero       out  1      diff == 0
//   ovf        out  1      two's-complement overflow: borrow into bit WIDTH-1 XOR bout
// BEHAVIOUR
//   Reset (rst_n low, asynchronous)
//   - state=IDLE; step counter, borrow, operand and result registers cleared.
//   - diff=0, bout=0, zero=0, ovf=0, out_valid=0, in_ready=1 (decoded from state).
//   - Reset in any state aborts the operation in flight; no partial result is ever presented.
//   FSM states: IDLE, RUN, DONE.
//   - IDLE: in_ready=1. Edge with in_valid=1 accepts the bundle:
//     latch a, b; borrow<=bin; cnt<=0; go to RUN.
//   - RUN: in_ready=0, out_valid=0. Each edge, for slice k=cnt:
//     {br,d} = a[k*DIGIT+:DIGIT] - b[k*DIGIT+:DIGIT] - borrow.
//     Write d into result[k*DIGIT+:DIGIT]; borrow<=br; cnt<=cnt+1.
//     On slice N-1: capture the bit-level borrow into the MSB for ovf, then go to DONE.
//   - DONE: out_valid=1; diff, bout, zero, ovf held stable.
//     Edge with out_ready=1 moves to IDLE; the result registers keep their value.
//   Latency and throughput
//   - out_valid rises exactly N clocks after the accepting edge.
//   - Earliest next acceptance is the edge after out_valid&&out_ready.
//   - Back-to-back operations with out_ready=1 therefore start every N+2 clocks.
//   Handshake rules
//   - in_valid is ignored outside IDLE; a, b, bin are sampled only at acceptance, so changes during RUN/DONE have no effect.
//   - out_ready is ignored outside DONE.
//   - Outputs must not change while out_valid=1 && out_ready=0.
//   Width and arithmetic rules
//   - All arithmetic is unsigned modulo 2^WIDTH.
//   - The per-slice borrow chain is DIGIT+1 bits wide.
//   - cnt is $clog2(N) bits wide (minimum 1) and wraps only through a new acceptance.
//   - zero and ovf are registered together with the final slice, not decoded from diff combinationally.
// TESTING  (WIDTH=16, DIGIT=4, N=4 unless stated)
//   1. a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, zero=0, ovf=0; out_valid rises 4 clocks after accept.
//   2. a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x5555, b=0x5554, bin=1 -> diff=0x0000, zero=1, bout=0.
//   3. a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, ovf=1, bout=0. Then a=0x8000, b=0x0000, bin=1 -> diff=0x7FFF, ovf=1.
//   4. Hold out_ready=0 for 6 clocks in DONE while pulsing in_valid with new operands
//      -> outputs stable, in_ready=0, new operands ignored.
//      Then release -> next accept one clock after the handshake; back-to-back period = 6 clocks.
//   5. Assert rst_n=0 mid-RUN after 2 slices -> out_valid=0 and diff=0 immediately, in_ready=1.
//      A following op a=0xFFFF, b=0x0F0F -> diff=0xF0F0.
//   6. Parameter sweep DIGIT in {1,4,16}: 2000 random a, b, bin vs reference model;
//      check latency = WIDTH/DIGIT and all four outputs.

Source files
------------

// File: rtl/serial_subtractor_dataflow.sv
// serial_subtractor_dataflow
//   Digit-serial subtractor computing diff = a - b - bin modulo 2^WIDTH.
//   Each RUN cycle handles one DIGIT-bit slice, starting with the least significant slice.
//   A borrow register chains consecutive slices together.
//   Operands enter through a valid/ready channel that is open only in IDLE.
//   The result leaves through a valid/ready channel and is held while the consumer stalls.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand bundle valid
//   in_ready   operands accepted (high only in IDLE)
//   a, b, bin  minuend, subtrahend, borrow-in (sampled only on acceptance)
//   out_valid  result valid (high only in DONE)
//   out_ready  consumer accepts the result
//   diff       a - b - bin modulo 2^WIDTH
//   bout       unsigned borrow-out (a < b + bin)
//   zero       diff == 0
//   ovf        two's-complement overflow of the subtraction

module serial_subtractor_dataflow #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               borrow_q, borrow_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               bout_q, bout_d;
  logic               zero_q, zero_d;
  logic               ovf_q, ovf_d;

  logic [DIGIT-1:0]   a_slice;
  logic [DIGIT-1:0]   b_slice;
  logic [DIGIT:0]     slice_full;
  logic               msb_borrow;
  logic               last_slice;

  // Select the slice addressed by the step counter and subtract it.
  // The subtraction is DIGIT+1 bits wide, so its top bit is the borrow out of the slice.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < N; k++) begin
      if (int'(cnt_q) == k) begin
        a_slice = a_q[k*DIGIT +: DIGIT];
        b_slice = b_q[k*DIGIT +: DIGIT];
      end
    end
    slice_full = {1'b0, a_slice} - {1'b0, b_slice} - {{DIGIT{1'b0}}, borrow_q};
    // The difference bit is a ^ b ^ borrow_in.
    // So the borrow into the slice MSB can be recovered as a ^ b ^ d at that bit.
    msb_borrow = a_slice[DIGIT-1] ^ b_slice[DIGIT-1] ^ slice_full[DIGIT-1];
    last_slice = (int'(cnt_q) == N - 1);
  end

  // Next-state logic: accept in IDLE, one slice per cycle in RUN, hold in DONE.
  // The flags are computed only on the final slice, so they change together with diff.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    bout_d   = bout_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          borrow_d = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (int'(cnt_q) == k) begin
            result_d[k*DIGIT +: DIGIT] = slice_full[DIGIT-1:0];
          end
        end
        borrow_d = slice_full[DIGIT];
        cnt_d    = cnt_q + CNT_W'(1);
        if (last_slice) begin
          bout_d  = slice_full[DIGIT];
          ovf_d   = msb_borrow ^ slice_full[DIGIT];
          zero_d  = (result_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // Reset clears everything, so a partially computed result is never visible after an abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign diff      = result_q;
  assign bout      = bout_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;

endmodule
